// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and types: default operand widths, tap count,
// accumulator width derivation, signed accumulator type and accumulator phase enum.
package cnn_pkg;

   localparam int DEF_INPUT  = 4;
   localparam int DEF_FILTER = 4;
   localparam int DEF_TAPS   = 9;

   // Four guard bits cover up to 16 taps of the worst-case product.
   function automatic int acc_width(input int input_w, input int filter_w);
      return input_w + filter_w + 4;
   endfunction

   localparam int DEF_ACC_W = acc_width(DEF_INPUT, DEF_FILTER);

   typedef logic signed [DEF_ACC_W-1:0] acc_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_phase_e;

endpackage

// File: rtl/relu_clamp.sv
// Combinational ReLU on a signed W-bit value: negative inputs become zero.
module relu_clamp #(
   parameter int W = 12
) (
   input  logic signed [W-1:0] din,
   output logic signed [W-1:0] dout
);

   assign dout = din[W-1] ? '0 : din;

endmodule

// File: rtl/conv_accumulator.sv
// Sums TAPS signed products per convolution window and emits a registered sum with a one-cycle valid.
// Optional: define CONV_ACC_RELU_EN to pass the completed sum through ReLU before the dout register.
//
// state | meaning
// IDLE  | count == 0, accumulator empty, next product loads acc
// ACCUM | count in 1..TAPS-1, window partially accumulated
module conv_accumulator
   import cnn_pkg::*;
#(
   parameter int INPUT  = DEF_INPUT,
   parameter int FILTER = DEF_FILTER,
   parameter int TAPS   = DEF_TAPS,
   parameter int ACC_W  = acc_width(INPUT, FILTER)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           Start,
   input  logic                           Clear,
   input  logic signed [INPUT+FILTER-1:0] din,
   output logic signed [ACC_W-1:0]        dout,
   output logic                           out_valid,
   output logic                           busy
);

   localparam int PW    = INPUT + FILTER;
   localparam int CNT_W = $clog2(TAPS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

   logic signed [ACC_W-1:0] acc, acc_nxt;
   logic signed [ACC_W-1:0] din_ext, sum, sum_out, dout_nxt;
   logic [CNT_W-1:0]        count, count_nxt;
   logic                    out_valid_nxt, busy_nxt;
   acc_phase_e              phase;

   assign din_ext = {{(ACC_W-PW){din[PW-1]}}, din};
   assign sum     = acc + din_ext;

`ifdef CONV_ACC_RELU_EN
   relu_clamp #(.W(ACC_W)) u_relu (
      .din  (sum),
      .dout (sum_out)
   );
`else
   assign sum_out = sum;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         count     <= '0;
         dout      <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         acc       <= acc_nxt;
         count     <= count_nxt;
         dout      <= dout_nxt;
         out_valid <= out_valid_nxt;
         busy      <= busy_nxt;
      end
   end

   always_comb begin
      acc_nxt       = acc;
      count_nxt     = count;
      dout_nxt      = dout;
      out_valid_nxt = 1'b0;
      phase         = (count == '0) ? IDLE : ACCUM;
      // Clear beats a simultaneous Start; dout and a pending pulse are untouched.
      if (Clear) begin
         acc_nxt   = '0;
         count_nxt = '0;
      end else if (Start) begin
         case (phase)
            IDLE: begin
               acc_nxt   = din_ext;
               count_nxt = CNT_W'(1);
            end
            ACCUM: begin
               if (count == LAST) begin
                  dout_nxt      = sum_out;
                  out_valid_nxt = 1'b1;
                  acc_nxt       = '0;
                  count_nxt     = '0;
               end else begin
                  acc_nxt   = sum;
                  count_nxt = count + CNT_W'(1);
               end
            end
            default: begin
               acc_nxt   = '0;
               count_nxt = '0;
            end
         endcase
      end
      busy_nxt = (count_nxt != '0);
   end

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed self-checking bench for conv_accumulator with hand-computed window sums.
module tb_conv_accumulator;
   import cnn_pkg::*;

`ifdef CONV_ACC_RELU_EN
   localparam int EXP_NEG1080 = 0;
   localparam int EXP_NEG9    = 0;
`else
   localparam int EXP_NEG1080 = -1080;
   localparam int EXP_NEG9    = -9;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              Start = 1'b0;
   logic              Clear = 1'b0;
   logic signed [7:0] din = '0;
   acc_t              dout;
   logic              out_valid;
   logic              busy;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int pulse_cyc = 0;

   conv_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .Start     (Start),
      .Clear     (Clear),
      .din       (din),
      .dout      (dout),
      .out_valid (out_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] observed,
                      input logic signed [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic feed(input int value);
      Start = 1'b1;
      din   = 8'(value);
      step();
      Start = 1'b0;
   endtask

   task automatic feed_window(input int value, input int taps, input string tag);
      for (int i = 0; i < taps - 1; i++) begin
         feed(value);
         chk({tag, "_no_early_valid"}, 32'(out_valid), 0);
      end
      feed(value);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_dout", dout, 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      step();
      rst_n = 1'b1;
      step();

      // Asynchronous reset mid-window discards the partial sum
      for (int i = 0; i < 4; i++) feed(5);
      chk("pre_rst_busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy), 0);
      #1 rst_n = 1'b1;
      step();
      feed_window(1, 9, "after_rst");
      chk("after_rst_valid", 32'(out_valid), 1);
      chk("after_rst_dout", dout, 9);
      step();
      chk("valid_one_cycle", 32'(out_valid), 0);
      chk("dout_hold", dout, 9);

      // Most negative window
      feed_window(-120, 9, "neg");
      chk("neg_valid", 32'(out_valid), 1);
      chk("neg_dout", dout, EXP_NEG1080);
      step();

      // Start gap after tap 4
      for (int v = 1; v <= 4; v++) feed(v);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("gap_busy", 32'(busy), 1);
         chk("gap_no_valid", 32'(out_valid), 0);
      end
      for (int v = 5; v <= 8; v++) feed(v);
      chk("gap_no_early_valid", 32'(out_valid), 0);
      feed(9);
      chk("gap_valid", 32'(out_valid), 1);
      chk("gap_dout", dout, 45);
      step();

      // Back-to-back windows, tap 0 of window 2 in the pulse cycle
      feed_window(105, 9, "b2b1");
      chk("b2b1_valid", 32'(out_valid), 1);
      chk("b2b1_dout", dout, 945);
      pulse_cyc = cyc;
      feed_window(-1, 9, "b2b2");
      chk("b2b2_valid", 32'(out_valid), 1);
      chk("b2b2_dout", dout, EXP_NEG9);
      chk("b2b_spacing", cyc - pulse_cyc, 9);
      step();
      chk("b2b_idle_busy", 32'(busy), 0);

      // Clear together with Start at tap 5
      for (int i = 0; i < 4; i++) feed(7);
      Clear = 1'b1;
      feed(50);
      Clear = 1'b0;
      chk("clear_busy", 32'(busy), 0);
      chk("clear_no_valid", 32'(out_valid), 0);
      chk("clear_dout_kept", dout, EXP_NEG9);
      feed_window(2, 9, "post_clear");
      chk("post_clear_valid", 32'(out_valid), 1);
      chk("post_clear_dout", dout, 18);

      // Clear (with a discarded product) during the pulse cycle
      Clear = 1'b1;
      feed(3);
      Clear = 1'b0;
      chk("pulse_clear_dout", dout, 18);
      chk("pulse_clear_valid_drop", 32'(out_valid), 0);
      chk("pulse_clear_busy", 32'(busy), 0);
      feed_window(1, 9, "after_pulse_clear");
      chk("after_pulse_clear_valid", 32'(out_valid), 1);
      chk("after_pulse_clear_dout", dout, 9);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/conv_accumulator.md
Name: conv_accumulator

Overview:
- Downstream stage of the image×filter multiplier in the two-layer CNN datapath.
- Consumes one signed product per Start-qualified cycle and sums TAPS products, one convolution window.
- Presents the registered window sum with a one-cycle valid pulse to the next layer or the feature-map buffer.
- Gaps in Start are tolerated; windows can run back-to-back with no idle cycle.

Parameters:
- INPUT, 4, pixel width (unsigned magnitude); matches multiplier.
- FILTER, 4, weight width (signed); matches multiplier.
- TAPS, 9, products per window (3x3 kernel); legal range 2..16.
- ACC_W, INPUT+FILTER+4, accumulator/output width. Must cover TAPS × worst product; 12 bits for the defaults.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  product valid; same strobe that drives the multiplier's Start.
- Clear  input  1  synchronous abort of the current window.
- din  input  INPUT+FILTER  signed product from the multiplier.
- dout  output  ACC_W  signed window sum, registered.
- out_valid  output  1  one-cycle pulse; dout is valid in this cycle.
- busy  output  1  high while a window is partially accumulated (count ≠ 0).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - acc, count, dout, out_valid and busy clear to 0.
  - Reset mid-window discards the partial sum.
- State is implicit in count (0..TAPS-1):
  - IDLE: count=0.
  - ACCUM: count 1..TAPS-1.
- Accepted product = Start=1 and Clear=0. Always sign-extend din to ACC_W.
  - count=0: acc ← din (load, no add); count ← 1.
  - 0<count<TAPS-1: acc ← acc+din; count ← count+1.
  - count=TAPS-1 (last tap): dout ← acc+din; out_valid ← 1 next cycle; acc ← 0; count ← 0.
- Latency: out_valid asserts the cycle after the TAPS-th accepted product.
- out_valid lasts exactly one cycle. dout holds its value until the next window completes.
- Start=0: acc and count hold; no timeout.
- Back-to-back windows: a product arriving in the cycle out_valid is high is tap 0 of the next window (count is already 0).
- Clear=1:
  - acc ← 0, count ← 0; Clear wins over a simultaneous Start, and that product is discarded.
  - dout and out_valid are unaffected: a pulse already scheduled still occurs.
- No overflow handling is needed: for the defaults the sum is bounded to [-1080, +945] and fits 12-bit signed.
- busy = (count ≠ 0), registered with count.

Optional Feature:
- Macro: CONV_ACC_RELU_EN.
- Defined: the completed sum passes through ReLU before the dout register (negative → 0, else unchanged). out_valid timing is identical.
- Undefined: dout is the raw signed sum.
- acc itself is never clamped in either mode.

Decomposition:
- Shared package cnn_pkg:
  - INPUT, FILTER, TAPS defaults.
  - ACC_W derivation and a signed accumulator typedef, shared with the multiplier and the next-layer blocks.
- One natural sub-module: relu_clamp, combinational, ACC_W in/out. Instantiated only under CONV_ACC_RELU_EN.
- Tap counter and accumulator stay inline.

Test Plan:
- Reset: rst_n low mid-window after 4 products, then release and feed 9 products of +1 → out_valid once, dout=9 (partial sum discarded).
- Nine products of -120 with Start continuous → out_valid the cycle after the 9th, dout=-1080 (0 with CONV_ACC_RELU_EN).
- Products 1..9 with Start dropped for 3 cycles after tap 4 → dout=45; out_valid one cycle after tap 9 with the gap adding no offset; busy high throughout the gap.
- Two windows back-to-back (all +105, then all -1) with no idle cycle → dout=945 then -9; out_valid pulses exactly 9 cycles apart; tap 0 of window 2 coincides with the first pulse.
- Clear asserted together with Start at tap 5 → product discarded; count=0; the next 9 products of +2 yield dout=18.
- Clear in the cycle out_valid is high → pulse and dout preserved; accumulator stays empty.
